// File: rtl/id_operand_hazard.sv
// id_operand_hazard: decode-stage operand resolution with EX > MEM (> WB)
// forwarding, load-use hazard detection, branch resolution on forwarded
// operands, and the registered ID/EX pipeline register.
// Optional feature macro: ID_WB_FWD_EN (adds WB as third forwarding source).
module id_operand_hazard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int REG_AW   = 4,
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [ADDR_W-1:0]   dec_pc,
  input  logic [ALUSEL_W-1:0] dec_alusel,
  input  logic [ALUOP_W-1:0]  dec_aluop,
  input  logic                dec_re0,
  input  logic                dec_re1,
  input  logic [REG_AW-1:0]   dec_raddr0,
  input  logic [REG_AW-1:0]   dec_raddr1,
  input  logic [DATA_W-1:0]   dec_imm,
  input  logic                dec_imm_sel,
  input  logic                dec_we,
  input  logic [REG_AW-1:0]   dec_waddr,
  input  logic                dec_is_load,
  input  logic [2:0]          dec_br_type,
  input  logic [ADDR_W-1:0]   dec_br_off,
  input  logic [DATA_W-1:0]   rf_rdata0,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic                ex_we,
  input  logic [REG_AW-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_is_load,
  input  logic                mem_we,
  input  logic [REG_AW-1:0]   mem_waddr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_waddr,
  input  logic [DATA_W-1:0]   wb_wdata,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                branch_flag_o,
  output logic [ADDR_W-1:0]   branch_addr_o,
  output logic                ex_valid_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [DATA_W-1:0]   ex_op0_o,
  output logic [DATA_W-1:0]   ex_op1_o,
  output logic                ex_we_o,
  output logic [REG_AW-1:0]   ex_waddr_o,
  output logic                ex_is_load_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  typedef enum logic {RUN, LDSTALL} state_e;

  state_e state_q, state_d;

  logic                hazard;
  logic                stall_take;
  logic [DATA_W-1:0]   fwd0, fwd1, op1;
  logic [ADDR_W-1:0]   br_tgt;

  logic                valid_q, valid_d, we_q, we_d, is_load_q, is_load_d;
  logic [ALUSEL_W-1:0] alusel_q, alusel_d;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [DATA_W-1:0]   op0_q, op0_d, op1_q, op1_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic re, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] rf,
    input logic exw, input logic exl, input logic [REG_AW-1:0] exa,
    input logic [DATA_W-1:0] exd,
    input logic mw, input logic [REG_AW-1:0] ma, input logic [DATA_W-1:0] md,
    input logic ww, input logic [REG_AW-1:0] wa, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] r;
    r = rf;
    if (!re)                        r = '0;
    else if (exw && !exl && exa == a) r = exd;
    else if (mw && ma == a)         r = md;
`ifdef ID_WB_FWD_EN
    else if (ww && wa == a)         r = wd;
`endif
    return r;
  endfunction

`ifndef ID_WB_FWD_EN
  // WB data is ignored in this build; the register file writes through.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
`endif

  // Operand forwarding and load-use hazard detection.
  always_comb begin
    fwd0 = fwd_sel(dec_re0, dec_raddr0, rf_rdata0, ex_we, ex_is_load, ex_waddr,
                   ex_wdata, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
    fwd1 = fwd_sel(dec_re1, dec_raddr1, rf_rdata1, ex_we, ex_is_load, ex_waddr,
                   ex_wdata, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
    op1  = dec_imm_sel ? dec_imm : fwd1;
    hazard = dec_valid && ex_we && ex_is_load &&
             ((dec_re0 && ex_waddr == dec_raddr0) ||
              (dec_re1 && ex_waddr == dec_raddr1));
    stall_take = hazard && !hold_i && !flush_i;
  end

  assign stall_req_o = hazard || hold_i;
  assign br_tgt      = dec_pc + dec_br_off;

  // Branch resolution against forwarded reg0.
  always_comb begin
    branch_flag_o = 1'b0;
    branch_addr_o = '0;
    if (dec_valid && !stall_req_o && !flush_i) begin
      case (dec_br_type)
        3'd1: begin branch_flag_o = 1'b1;          branch_addr_o = br_tgt; end
        3'd2: begin branch_flag_o = (fwd0 == '0);  branch_addr_o = br_tgt; end
        3'd3: begin branch_flag_o = (fwd0 != '0);  branch_addr_o = br_tgt; end
        3'd4: begin branch_flag_o = 1'b1;          branch_addr_o = fwd0[ADDR_W-1:0]; end
        default: ;
      endcase
    end
  end

  // Stall FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall_take) state_d = LDSTALL;
      LDSTALL: state_d = hazard ? LDSTALL : RUN;
      default: state_d = RUN;
    endcase
  end

  // ID/EX next state: flush > hold > bubble > load.
  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    alusel_d  = alusel_q;
    aluop_d   = aluop_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    waddr_d   = waddr_q;
    cnt_d     = (stall_take && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (flush_i || (!hold_i && hazard)) begin
      valid_d   = 1'b0;
      we_d      = 1'b0;
      is_load_d = 1'b0;
      alusel_d  = '0;
      aluop_d   = '0;
      op0_d     = '0;
      op1_d     = '0;
      waddr_d   = '0;
    end else if (!hold_i) begin
      valid_d   = dec_valid;
      we_d      = dec_we && dec_valid;
      is_load_d = dec_is_load;
      alusel_d  = dec_alusel;
      aluop_d   = dec_aluop;
      op0_d     = fwd0;
      op1_d     = op1;
      waddr_d   = dec_waddr;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      alusel_q  <= '0;
      aluop_q   <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      alusel_q  <= alusel_d;
      aluop_q   <= aluop_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      waddr_q   <= waddr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_we_o      = we_q;
  assign ex_is_load_o = is_load_q;
  assign ex_alusel_o  = alusel_q;
  assign ex_aluop_o   = aluop_q;
  assign ex_op0_o     = op0_q;
  assign ex_op1_o     = op1_q;
  assign ex_waddr_o   = waddr_q;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_operand_hazard.sv
// Scoreboard bench for id_operand_hazard: directed test-plan vectors then
// randomized cycles, checked against a rule-level reference model.
module tb_id_operand_hazard;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dec_valid, dec_re0, dec_re1, dec_imm_sel, dec_we, dec_is_load;
  logic [15:0] dec_pc, dec_imm, dec_br_off, rf_rdata0, rf_rdata1;
  logic [2:0]  dec_alusel, dec_br_type;
  logic [7:0]  dec_aluop;
  logic [3:0]  dec_raddr0, dec_raddr1, dec_waddr, ex_waddr, mem_waddr, wb_waddr;
  logic        ex_we, ex_is_load, mem_we, wb_we, hold_i, flush_i;
  logic [15:0] ex_wdata, mem_wdata, wb_wdata;

  logic        stall_req_o, branch_flag_o, ex_valid_o, ex_we_o, ex_is_load_o;
  logic [15:0] branch_addr_o, ex_op0_o, ex_op1_o;
  logic [2:0]  ex_alusel_o;
  logic [7:0]  ex_aluop_o;
  logic [3:0]  ex_waddr_o;
  logic [CW-1:0] stall_cnt_o;

  id_operand_hazard #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_alusel(dec_alusel), .dec_aluop(dec_aluop), .dec_re0(dec_re0),
    .dec_re1(dec_re1), .dec_raddr0(dec_raddr0), .dec_raddr1(dec_raddr1),
    .dec_imm(dec_imm), .dec_imm_sel(dec_imm_sel), .dec_we(dec_we),
    .dec_waddr(dec_waddr), .dec_is_load(dec_is_load), .dec_br_type(dec_br_type),
    .dec_br_off(dec_br_off), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .hold_i(hold_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
    .branch_flag_o(branch_flag_o), .branch_addr_o(branch_addr_o),
    .ex_valid_o(ex_valid_o), .ex_alusel_o(ex_alusel_o), .ex_aluop_o(ex_aluop_o),
    .ex_op0_o(ex_op0_o), .ex_op1_o(ex_op1_o), .ex_we_o(ex_we_o),
    .ex_waddr_o(ex_waddr_o), .ex_is_load_o(ex_is_load_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic stall; logic bflag; logic [15:0] baddr;
  } comb_t;

  typedef struct {
    logic valid; logic [2:0] alusel; logic [7:0] aluop;
    logic [15:0] op0, op1; logic we; logic [3:0] waddr; logic is_load;
    int cnt; logic bubble;
  } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  reg_t  m;
  int    tests = 0, fails = 0;
  bit    done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first matching producer in priority order, else register file.
  function automatic logic [15:0] m_fwd(input logic re, input logic [3:0] a,
                                        input logic [15:0] rf);
    logic [3:0]  srca[$];
    logic [15:0] srcd[$];
    if (!re) return 16'h0;
    if (ex_we && !ex_is_load) begin srca.push_back(ex_waddr); srcd.push_back(ex_wdata); end
    if (mem_we) begin srca.push_back(mem_waddr); srcd.push_back(mem_wdata); end
`ifdef ID_WB_FWD_EN
    if (wb_we) begin srca.push_back(wb_waddr); srcd.push_back(wb_wdata); end
`endif
    foreach (srca[i]) if (srca[i] == a) return srcd[i];
    return rf;
  endfunction

  task automatic eval();
    comb_t c;
    logic  hz;
    logic [15:0] f0, f1;
    int    tgt;
    f0 = m_fwd(dec_re0, dec_raddr0, rf_rdata0);
    f1 = m_fwd(dec_re1, dec_raddr1, rf_rdata1);
    hz = dec_valid && ex_we && ex_is_load &&
         ((dec_re0 && ex_waddr == dec_raddr0) || (dec_re1 && ex_waddr == dec_raddr1));
    c.stall = hz || hold_i;
    c.bflag = 1'b0;
    c.baddr = 16'h0;
    tgt = (int'(dec_pc) + int'(dec_br_off)) % 65536;
    if (dec_valid && !c.stall && !flush_i) begin
      if (dec_br_type == 3'd1) begin c.bflag = 1'b1; c.baddr = 16'(tgt); end
      if (dec_br_type == 3'd2) begin c.bflag = (f0 == 0); c.baddr = 16'(tgt); end
      if (dec_br_type == 3'd3) begin c.bflag = (f0 != 0); c.baddr = 16'(tgt); end
      if (dec_br_type == 3'd4) begin c.bflag = 1'b1; c.baddr = f0; end
    end
    cq.push_back(c);
    if (!rst) begin
      m = '{default: 0};
    end else if (flush_i) begin
      m = '{valid: 0, alusel: 0, aluop: 0, op0: 0, op1: 0, we: 0, waddr: 0,
            is_load: 0, cnt: m.cnt, bubble: 0};
    end else if (hold_i) begin
      // everything held
    end else if (hz) begin
      m.valid = 0; m.we = 0; m.alusel = 0; m.aluop = 0; m.bubble = 1;
      if (m.cnt < (1 << CW) - 1) m.cnt++;
    end else begin
      m = '{valid: dec_valid, alusel: dec_alusel, aluop: dec_aluop, op0: f0,
            op1: dec_imm_sel ? dec_imm : f1, we: dec_we && dec_valid,
            waddr: dec_waddr, is_load: dec_is_load, cnt: m.cnt, bubble: 0};
    end
    #5;
    rq.push_back(m);
  endtask

  task automatic idle();
    rst = 1; dec_valid = 0; dec_pc = 0; dec_alusel = 0; dec_aluop = 0;
    dec_re0 = 0; dec_re1 = 0; dec_raddr0 = 0; dec_raddr1 = 0; dec_imm = 0;
    dec_imm_sel = 0; dec_we = 0; dec_waddr = 0; dec_is_load = 0; dec_br_type = 0;
    dec_br_off = 0; rf_rdata0 = 16'h1111; rf_rdata1 = 16'h2222;
    ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    hold_i = 0; flush_i = 0;
  endtask

  task automatic randomize_inputs();
    rst = ($urandom_range(0, 49) != 0);
    dec_valid = ($urandom_range(0, 3) != 0);
    dec_pc = 16'($urandom); dec_alusel = 3'($urandom); dec_aluop = 8'($urandom);
    dec_re0 = 1'($urandom); dec_re1 = 1'($urandom);
    dec_raddr0 = 4'($urandom_range(0, 3)); dec_raddr1 = 4'($urandom_range(0, 3));
    dec_imm = 16'($urandom); dec_imm_sel = 1'($urandom);
    dec_we = 1'($urandom); dec_waddr = 4'($urandom); dec_is_load = 1'($urandom);
    dec_br_type = 3'($urandom); dec_br_off = 16'($urandom);
    rf_rdata0 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    rf_rdata1 = 16'($urandom);
    ex_we = 1'($urandom); ex_waddr = 4'($urandom_range(0, 3));
    ex_wdata = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    ex_is_load = ($urandom_range(0, 2) == 0);
    mem_we = 1'($urandom); mem_waddr = 4'($urandom_range(0, 3)); mem_wdata = 16'($urandom);
    wb_we = 1'($urandom); wb_waddr = 4'($urandom_range(0, 3)); wb_wdata = 16'($urandom);
    hold_i = ($urandom_range(0, 7) == 0);
    flush_i = ($urandom_range(0, 9) == 0);
  endtask

  // Combinational outputs checked mid-cycle.
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      comb_t c;
      c = cq.pop_front();
      chk("stall_req", 32'(stall_req_o), 32'(c.stall));
      chk("branch_flag", 32'(branch_flag_o), 32'(c.bflag));
      chk("branch_addr", 32'(branch_addr_o), 32'(c.baddr));
    end
  end

  // Registered outputs checked just after the edge that loaded them.
  always @(posedge clk) begin
    #2;
    if (rq.size() > 0) begin
      reg_t e;
      e = rq.pop_front();
      chk("ex_valid", 32'(ex_valid_o), 32'(e.valid));
      chk("ex_we", 32'(ex_we_o), 32'(e.we));
      chk("ex_alusel", 32'(ex_alusel_o), 32'(e.alusel));
      chk("ex_aluop", 32'(ex_aluop_o), 32'(e.aluop));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(e.cnt));
      if (!e.bubble) begin
        chk("ex_op0", 32'(ex_op0_o), 32'(e.op0));
        chk("ex_op1", 32'(ex_op1_o), 32'(e.op1));
        chk("ex_waddr", 32'(ex_waddr_o), 32'(e.waddr));
        chk("ex_is_load", 32'(ex_is_load_o), 32'(e.is_load));
      end
    end
  end

  task automatic step_begin();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    // reset
    step_begin(); rst = 0; eval();
    // EX forwarding of ALU result; op1 from register file
    step_begin(); ex_we = 1; ex_waddr = 2; ex_wdata = 16'h1234;
    dec_valid = 1; dec_re0 = 1; dec_raddr0 = 2; dec_re1 = 1; dec_raddr1 = 3;
    rf_rdata1 = 16'h0005; dec_we = 1; dec_waddr = 6; eval();
    // load-use hazard then MEM forwarding of the loaded value
    step_begin(); ex_we = 1; ex_is_load = 1; ex_waddr = 1;
    dec_valid = 1; dec_re0 = 1; dec_raddr0 = 1; eval();
    step_begin(); mem_we = 1; mem_waddr = 1; mem_wdata = 16'hBEEF;
    dec_valid = 1; dec_re0 = 1; dec_raddr0 = 1; eval();
    // BEQZ with R4 forwarded from MEM, zero then nonzero
    for (int v = 0; v < 2; v++) begin
      step_begin(); dec_valid = 1; dec_br_type = 2; dec_re0 = 1; dec_raddr0 = 4;
      dec_pc = 16'h0010; dec_br_off = 16'hFFFE; rf_rdata0 = 16'h0099;
      mem_we = 1; mem_waddr = 4; mem_wdata = (v == 0) ? 16'h0 : 16'h7; eval();
    end
    // JR R7 via EX forwarding, then same under hold
    for (int h = 0; h < 2; h++) begin
      step_begin(); dec_valid = 1; dec_br_type = 4; dec_re0 = 1; dec_raddr0 = 7;
      ex_we = 1; ex_waddr = 7; ex_wdata = 16'h0400; dec_aluop = 8'h5A;
      hold_i = 1'(h); eval();
    end
    // flush with hazard pending; then hazard followed by reset mid-stall
    step_begin(); ex_we = 1; ex_is_load = 1; ex_waddr = 3;
    dec_valid = 1; dec_re1 = 1; dec_raddr1 = 3; flush_i = 1; eval();
    step_begin(); ex_we = 1; ex_is_load = 1; ex_waddr = 3;
    dec_valid = 1; dec_re1 = 1; dec_raddr1 = 3; eval();
    step_begin(); rst = 0; ex_we = 1; ex_is_load = 1; ex_waddr = 3;
    dec_valid = 1; dec_re1 = 1; dec_raddr1 = 3; eval();
    // only WB writes R5
    step_begin(); wb_we = 1; wb_waddr = 5; wb_wdata = 16'h00AA; rf_rdata0 = 16'h5555;
    dec_valid = 1; dec_re0 = 1; dec_raddr0 = 5; eval();
    // counter saturation with hazard held asserted
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      step_begin(); ex_we = 1; ex_is_load = 1; ex_waddr = 2;
      dec_valid = 1; dec_re0 = 1; dec_raddr0 = 2; eval();
    end
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      randomize_inputs();
      eval();
    end
    done = 1;
    for (int i = 0; i < 10 && (cq.size() > 0 || rq.size() > 0); i++) @(posedge clk);
    #5;
    tests++;
    if (cq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", cq.size() + rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
